dmac_copy: RTL and testbench
============================

# dmac_copy

Memory-to-memory copy engine that masters the 64-word, 32-bit single-port synchronous RAM through its `cen`/`wen`/`addr`/`din`/`dout` port. On a `start` pulse it copies `length` consecutive words from `src_addr` to `dst_addr`, one read cycle and one write cycle per word. It sits between the DMAC control logic, which supplies the transfer descriptor, and the RAM, which it drives directly. It is the initiator end of the RAM protocol.

## Interface
- `ADDR_W`, 16: address width, matching the RAM `addr` port.
- `DATA_W`, 32: data width, matching the RAM `din`/`dout` ports.
- `LEN_W`, 7: width of `length`, which covers 0..64.
- `MAX_LEN`, 64: largest legal transfer, equal to the RAM depth.
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `src_addr` in ADDR_W: first source word address. Captured at start.
- `dst_addr` in ADDR_W: first destination word address. Captured at start.
- `length` in LEN_W: word count. Captured at start.
- `m_cen` out 1: RAM chip enable.
- `m_wen` out 1: RAM write enable. 1 means write, 0 means read.
- `m_addr` out ADDR_W: RAM address.
- `m_din` out DATA_W: RAM write data.
- `m_dout` in DATA_W: RAM read data. Valid in the cycle after a read is issued.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: set with `done` when `length > MAX_LEN`. Held until the next accepted start.
- `words_done` out LEN_W: number of words written so far in the current or last transfer.

## Operation
- States are IDLE, READ, WRITE and DONE.
- **Reset** (`reset_n` low, applies immediately):
  - state goes to IDLE;
  - `m_cen`, `m_wen`, `busy`, `done` and `err` go to 0;
  - `m_addr`, `m_din` and `words_done` go to 0.
  - Reset during a transfer abandons it. Words already written stay in the RAM; no `done` pulse is produced.
- **IDLE**
  - `start` = 1 captures `src_addr`, `dst_addr` and `length`, clears `words_done` and clears `err`.
  - Next state is READ if 1 ≤ `length` ≤ MAX_LEN.
  - Next state is DONE if `length` = 0.
  - Next state is DONE with `err` set if `length` > MAX_LEN. No RAM access is made in either DONE case.
- **READ** (word i, i = 0..N-1)
  - Drive `m_cen`=1, `m_wen`=0, `m_addr` = src+i, `m_din` = 0.
  - Next state is always WRITE.
- **WRITE** (word i)
  - Drive `m_cen`=1, `m_wen`=1, `m_addr` = dst+i, `m_din` = `m_dout` (combinational pass-through of the data read in the previous cycle).
  - At the clock edge, `words_done` increments.
  - Next state is READ if i+1 < N, otherwise DONE.
- **DONE**
  - `done` = 1 for exactly one cycle; `busy` = 0.
  - Next state is always IDLE.
- **Outputs outside READ/WRITE**: `m_cen`=0, `m_wen`=0, `m_addr`=0, `m_din`=0. The RAM treats cen=0 as no access.
- `busy` = 1 exactly in READ and WRITE.
- `start` outside IDLE is ignored. It is not queued.
- **Address arithmetic**: src+i and dst+i are computed modulo 2^ADDR_W. The RAM decodes only `addr[5:0]`, so physical accesses wrap at 64. For example, src = 62 with N = 4 reads 62, 63, 0, 1.
- **Overlapping regions**: words are copied in ascending order, read before write for each word. If dst > src and the regions overlap, words written earlier are read back as source later; this is the defined behaviour.
- `length`, `src_addr` and `dst_addr` changing after capture have no effect on the current transfer.

## Timing
- Start accepted at edge E0. READ of word i is in cycle 2i+1 after E0; WRITE of word i is in cycle 2i+2.
- For N ≥ 1 words: `busy` is high for 2N cycles and `done` is high in cycle 2N+1 after E0.
- For N = 0 or an error: `done` is high in cycle 1 after E0 and `busy` never rises.
- Earliest next start is sampled in the cycle after `done`, i.e. 2N+2 cycles after E0 for N ≥ 1.
- Throughput is 2 cycles per word. No idle cycles between words.
- The RAM write of word i takes effect at the edge that ends its WRITE cycle. `words_done` equals i+1 after that same edge.

## Test plan
- **Basic copy**: preload mem[0..3] = 11,22,33,44; start with src=0, dst=8, len=4 -> mem[8..11] = 11,22,33,44; `busy` high 8 cycles; `done` in cycle 9; `words_done` = 4; `err` = 0.
- **Zero length and oversize**: len=0 -> `done` in cycle 1, `err`=0, `m_cen` never 1. len=65 -> `done` in cycle 1, `err`=1, no RAM access, memory unchanged.
- **Wrap-around**: mem[62]=A, mem[63]=B, mem[0]=C; src=62, dst=20, len=3 -> `m_addr` read sequence 62, 63, 64; mem[20..22] = A,B,C.
- **Overlap and full depth**: mem[i] = i for all i. src=0, dst=1, len=4 -> mem[1..4] = 0,0,0,0. A separate len=64 copy completes with `done` in cycle 129 and `words_done` = 64.
- **Start during busy, and reset mid-transfer**:
  - A second `start` in cycle 3 of a 4-word copy is ignored: exactly one `done`, target values unchanged from the basic copy.
  - Assert `reset_n`=0 during the WRITE of word 1 -> outputs go to 0 immediately, no `done`, mem[dst] holds word 0 only.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/dmac_copy.sv
// dmac_copy: memory-to-memory copy engine driving a single-port synchronous RAM.
// Each word costs one READ cycle followed by one WRITE cycle. The read data
// returned in WRITE is passed straight through to the RAM write data.
module dmac_copy #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 7,
   parameter int MAX_LEN = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              m_cen,
   output logic              m_wen,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_din,
   input  logic [DATA_W-1:0] m_dout,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_wcnt;
   logic              r_err;
   logic              w_len_bad;
   logic              w_len_zero;
   logic              w_last;
   logic [LEN_W-1:0]  w_wcnt_inc;

   assign w_len_bad  = (length > LEN_W'(MAX_LEN));
   assign w_len_zero = (length == '0);
   assign w_wcnt_inc = r_wcnt + LEN_W'(1);
   assign w_last     = (w_wcnt_inc >= r_len);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Descriptor capture, word counter and sticky error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_len  <= '0;
         r_wcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_len  <= length;
            r_wcnt <= '0;
            r_err  <= w_len_bad;
         end else if (r_state == S_WRITE) begin
            r_wcnt <= w_wcnt_inc;
         end
      end
   end

   // Next-state and RAM-side outputs; the word counter doubles as the word index
   always_comb begin
      w_next = r_state;
      m_cen  = 1'b0;
      m_wen  = 1'b0;
      m_addr = '0;
      m_din  = '0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_len_zero || w_len_bad) w_next = S_DONE;
               else                         w_next = S_READ;
            end
         end
         S_READ: begin
            m_cen  = 1'b1;
            m_addr = r_src + ADDR_W'(r_wcnt);
            busy   = 1'b1;
            w_next = S_WRITE;
         end
         S_WRITE: begin
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_addr = r_dst + ADDR_W'(r_wcnt);
            m_din  = m_dout;
            busy   = 1'b1;
            w_next = w_last ? S_DONE : S_READ;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign err        = r_err;
   assign words_done = r_wcnt;

endmodule

// File: tb/tb_dmac_copy.sv
// tb_dmac_copy: directed test of dmac_copy against a 64-word behavioural RAM.
module tb_dmac_copy;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [6:0]  length;
   logic        m_cen;
   logic        m_wen;
   logic [15:0] m_addr;
   logic [31:0] m_din;
   logic [31:0] m_dout;
   logic        busy;
   logic        done;
   logic        err;
   logic [6:0]  words_done;

   logic [31:0] mem [64];
   logic        ld_we;
   logic [5:0]  ld_a;
   logic [31:0] ld_d;

   int n_vec;
   int n_miss;

   int          r_done_cyc;
   int          r_done_cnt;
   int          r_busy_cnt;
   bit          r_cen_seen;
   logic [15:0] rd_addrs [$];

   dmac_copy #(.ADDR_W(16), .DATA_W(32), .LEN_W(7), .MAX_LEN(64)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .m_cen      (m_cen),
      .m_wen      (m_wen),
      .m_addr     (m_addr),
      .m_din      (m_din),
      .m_dout     (m_dout),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .words_done (words_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: decodes addr[5:0], read data valid the cycle after a read
   always @(posedge clk) begin
      if (ld_we) mem[ld_a] <= ld_d;
      else if (m_cen) begin
         if (m_wen) mem[m_addr[5:0]] <= m_din;
         else       m_dout <= mem[m_addr[5:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic load(input int a, input logic [31:0] d);
      @(negedge clk);
      ld_we = 1'b1;
      ld_a  = 6'(a);
      ld_d  = d;
      @(posedge clk);
      #1 ld_we = 1'b0;
   endtask

   // Start a transfer at edge E0 and observe ncyc cycles after it.
   // inj > 0 pulses a stray start across the edge ending cycle inj.
   // rst > 0 asserts reset in cycle rst and releases it two cycles later.
   task automatic run(input int src, input int dst, input int len, input int ncyc,
                      input int inj, input int rst);
      r_done_cyc = 0;
      r_done_cnt = 0;
      r_busy_cnt = 0;
      r_cen_seen = 0;
      rd_addrs.delete();
      @(negedge clk);
      start    = 1'b1;
      src_addr = 16'(src);
      dst_addr = 16'(dst);
      length   = 7'(len);
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == inj) begin
            start    = 1'b1;
            src_addr = 16'd0;
            dst_addr = 16'd30;
            length   = 7'd2;
         end else begin
            start = 1'b0;
         end
         if (k == rst) begin
            reset_n = 1'b0;
            #1;
            check("rst_cen",   32'(m_cen), 0);
            check("rst_busy",  32'(busy), 0);
            check("rst_addr",  32'(m_addr), 0);
            check("rst_wdone", 32'(words_done), 0);
         end
         if (rst > 0 && k == rst + 2) reset_n = 1'b1;
         if (busy) r_busy_cnt++;
         if (m_cen) r_cen_seen = 1;
         if (m_cen && !m_wen) rd_addrs.push_back(m_addr);
         if (done) begin
            r_done_cnt++;
            if (r_done_cyc == 0) r_done_cyc = k;
         end
      end
   endtask

   initial begin
      n_vec    = 0;
      n_miss   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      length   = '0;
      ld_we    = 1'b0;
      ld_a     = '0;
      ld_d     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cen",   32'(m_cen), 0);
      check("reset_wen",   32'(m_wen), 0);
      check("reset_busy",  32'(busy), 0);
      check("reset_done",  32'(done), 0);
      check("reset_err",   32'(err), 0);
      check("reset_addr",  32'(m_addr), 0);
      check("reset_din",   m_din, 0);
      check("reset_wdone", 32'(words_done), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Basic copy
      load(0, 11); load(1, 22); load(2, 33); load(3, 44);
      run(0, 8, 4, 12, 0, 0);
      check("basic_done_cyc", 32'(r_done_cyc), 9);
      check("basic_busy",     32'(r_busy_cnt), 8);
      check("basic_done_cnt", 32'(r_done_cnt), 1);
      check("basic_wdone",    32'(words_done), 4);
      check("basic_err",      32'(err), 0);
      check("basic_m8",  mem[8], 11);
      check("basic_m9",  mem[9], 22);
      check("basic_m10", mem[10], 33);
      check("basic_m11", mem[11], 44);

      // Stray start during busy is ignored
      load(30, 32'hDEAD);
      run(0, 8, 4, 14, 3, 0);
      check("inj_done_cyc", 32'(r_done_cyc), 9);
      check("inj_done_cnt", 32'(r_done_cnt), 1);
      check("inj_m8",  mem[8], 11);
      check("inj_m11", mem[11], 44);
      check("inj_m30", mem[30], 32'hDEAD);

      // Zero length
      run(0, 8, 0, 4, 0, 0);
      check("zero_done_cyc", 32'(r_done_cyc), 1);
      check("zero_err",      32'(err), 0);
      check("zero_cen",      32'(r_cen_seen), 0);
      check("zero_busy",     32'(r_busy_cnt), 0);

      // Oversize length
      run(0, 8, 65, 4, 0, 0);
      check("over_done_cyc", 32'(r_done_cyc), 1);
      check("over_err",      32'(err), 1);
      check("over_cen",      32'(r_cen_seen), 0);
      check("over_m8",       mem[8], 11);

      // Wrap-around of source addresses
      load(62, 32'hA); load(63, 32'hB); load(0, 32'hC);
      run(62, 20, 3, 10, 0, 0);
      check("wrap_err",    32'(err), 0);
      check("wrap_nrd",    32'(rd_addrs.size()), 3);
      if (rd_addrs.size() == 3) begin
         check("wrap_rd0", 32'(rd_addrs[0]), 62);
         check("wrap_rd1", 32'(rd_addrs[1]), 63);
         check("wrap_rd2", 32'(rd_addrs[2]), 64);
      end
      check("wrap_m20", mem[20], 32'hA);
      check("wrap_m21", mem[21], 32'hB);
      check("wrap_m22", mem[22], 32'hC);

      // Reset during WRITE of word 1
      load(0, 11);
      load(40, 0); load(41, 0);
      run(0, 40, 4, 12, 0, 4);
      check("rmid_done_cnt", 32'(r_done_cnt), 0);
      check("rmid_m40", mem[40], 11);
      check("rmid_m41", mem[41], 0);

      // Normal copy after reset
      run(0, 48, 2, 8, 0, 0);
      check("post_done_cyc", 32'(r_done_cyc), 5);
      check("post_wdone",    32'(words_done), 2);
      check("post_m48", mem[48], 11);
      check("post_m49", mem[49], 22);

      // Overlapping forward copy
      for (int i = 0; i < 64; i++) load(i, 32'(i));
      run(0, 1, 4, 12, 0, 0);
      check("ovl_m1", mem[1], 0);
      check("ovl_m2", mem[2], 0);
      check("ovl_m3", mem[3], 0);
      check("ovl_m4", mem[4], 0);
      check("ovl_m5", mem[5], 5);

      // Full-depth copy
      run(0, 0, 64, 132, 0, 0);
      check("full_done_cyc", 32'(r_done_cyc), 129);
      check("full_busy",     32'(r_busy_cnt), 128);
      check("full_wdone",    32'(words_done), 64);
      check("full_err",      32'(err), 0);
      check("full_m63",      mem[63], 63);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
